// File: rtl/bert_error_counter.sv
// BER measurement stage: compares received words with the PRBS reference on the
// active lanes and accumulates saturating bit-error / bit-compared totals after lock.
`timescale 1ns/1ps
module bert_error_counter #(
  parameter int DW         = 32,
  parameter int CNT_W      = 32,
  parameter int LOCK_WORDS = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             channel_reset,
  input  logic [2:0]       datawidth,
  input  logic             start,
  input  logic [15:0]      window_len,
  input  logic             rx_valid,
  input  logic [DW-1:0]    rx_data,
  input  logic [DW-1:0]    exp_data,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             locked,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int E_W = $clog2(DW + 1);
  localparam int S_W = $clog2(LOCK_WORDS + 1);

  // rx_valid qualifies rx_data/exp_data for exactly one cycle; there is no ready,
  // every valid word is consumed in the cycle it is presented.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       dw_q;
  logic [15:0]      win_q;
  logic [E_W-1:0]   e_q;
  logic             v1_q;
  logic [S_W-1:0]   streak_q;
  logic [15:0]      words_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] bit_q;

  logic [E_W-1:0]   lanes;
  logic [DW-1:0]    mask;
  logic [DW-1:0]    diff;
  logic [E_W-1:0]   pop_d;

  // Lane codes 5..7 all select the full 32-lane width, capped at DW.
  always_comb begin
    lanes = E_W'(DW);
    if (dw_q < 3'd5 && int'(32'd1 << dw_q) < DW) lanes = E_W'(32'd1 << dw_q);
    mask = '0;
    for (int i = 0; i < DW; i++) begin
      if (i < int'(lanes)) mask[i] = 1'b1;
    end
    diff  = (rx_data ^ exp_data) & mask;
    pop_d = '0;
    for (int i = 0; i < DW; i++) begin
      pop_d = pop_d + E_W'(diff[i]);
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [E_W-1:0]   b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dw_q     <= '0;
      win_q    <= '0;
      e_q      <= '0;
      v1_q     <= 1'b0;
      streak_q <= '0;
      words_q  <= '0;
      err_q    <= '0;
      bit_q    <= '0;
    end else if (channel_reset) begin
      state_q  <= IDLE;
      dw_q     <= '0;
      win_q    <= '0;
      e_q      <= '0;
      v1_q     <= 1'b0;
      streak_q <= '0;
      words_q  <= '0;
      err_q    <= '0;
      bit_q    <= '0;
    end else begin
      e_q  <= pop_d;
      v1_q <= rx_valid;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= SYNC;
            dw_q     <= datawidth;
            win_q    <= window_len;
            streak_q <= '0;
          end
        end
        SYNC: begin
          if (v1_q) begin
            if (e_q != '0) begin
              streak_q <= '0;
            end else if (streak_q == S_W'(LOCK_WORDS - 1)) begin
              // The lock word itself is not counted; totals restart here.
              state_q  <= MEASURE;
              streak_q <= '0;
              words_q  <= '0;
              err_q    <= '0;
              bit_q    <= '0;
            end else begin
              streak_q <= streak_q + S_W'(1);
            end
          end
        end
        MEASURE: begin
          if (v1_q) begin
            err_q   <= sat_add(err_q, e_q);
            bit_q   <= sat_add(bit_q, lanes);
            words_q <= words_q + 16'd1;
            if (win_q != 16'd0 && (words_q + 16'd1) == win_q) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err_count = err_q;
  assign bit_count = bit_q;
  assign locked    = (state_q == MEASURE) || (state_q == DONE);
  assign busy      = (state_q == SYNC) || (state_q == MEASURE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bert_error_counter.sv
// Directed bench for bert_error_counter: a 32-bit counter instance for the main
// flows and an 8-bit counter instance for saturation; results go through exp_q.
`timescale 1ns/1ps
module tb_bert_error_counter;

  logic        clock;
  logic        rst_n;
  logic        channel_reset;
  logic [2:0]  datawidth;
  logic        start;
  logic [15:0] window_len;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic [31:0] exp_data;
  logic [31:0] err_count;
  logic [31:0] bit_count;
  logic        locked;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  logic        s_channel_reset;
  logic [2:0]  s_datawidth;
  logic        s_start;
  logic [15:0] s_window_len;
  logic [7:0]  s_err_count;
  logic [7:0]  s_bit_count;
  logic        s_locked;
  logic        s_busy;
  logic        s_done;
  logic [1:0]  s_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int m_err   = 0;
  int m_bit   = 0;
  int m_lanes = 32;
  logic [31:0] m_mask = '1;
  logic [63:0] exp_q[$];

  bert_error_counter #(.DW(32), .CNT_W(32), .LOCK_WORDS(4)) u_dut (
    .clock(clock), .rst_n(rst_n), .channel_reset(channel_reset),
    .datawidth(datawidth), .start(start), .window_len(window_len),
    .rx_valid(rx_valid), .rx_data(rx_data), .exp_data(exp_data),
    .err_count(err_count), .bit_count(bit_count), .locked(locked),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  bert_error_counter #(.DW(32), .CNT_W(8), .LOCK_WORDS(4)) u_sat (
    .clock(clock), .rst_n(rst_n), .channel_reset(s_channel_reset),
    .datawidth(s_datawidth), .start(s_start), .window_len(s_window_len),
    .rx_valid(rx_valid), .rx_data(rx_data), .exp_data(exp_data),
    .err_count(s_err_count), .bit_count(s_bit_count), .locked(s_locked),
    .busy(s_busy), .done(s_done), .dbg_state(s_dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void set_model(input logic [2:0] code);
    m_lanes = (code >= 3'd5) ? 32 : (1 << code);
    m_mask  = (m_lanes == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_lanes) - 32'd1);
    m_err   = 0;
    m_bit   = 0;
  endfunction

  function automatic int sat8(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // driver tasks: inputs change on the falling edge, outputs are read there too
  task automatic pulse_start(input logic [2:0] code, input logic [15:0] win);
    datawidth  = code;
    window_len = win;
    start      = 1'b1;
    @(negedge clock);
    start      = 1'b0;
    datawidth  = 3'd0;
    window_len = 16'd1;
    set_model(code);
  endtask

  task automatic send(input logic [31:0] rx, input logic [31:0] ex, input bit counted);
    rx_valid = 1'b1;
    rx_data  = rx;
    exp_data = ex;
    if (counted) begin
      m_err += $countones((rx ^ ex) & m_mask);
      m_bit += m_lanes;
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_clean(input int n, input bit counted);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom;
      send(r, r, counted);
    end
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    chk(tag, done, 1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] e_obs, input logic [31:0] b_obs);
    logic [63:0] e;
    chk({tag, " queue"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " err_count"}, e_obs, e[63:32]);
      chk({tag, " bit_count"}, b_obs, e[31:0]);
    end
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; channel_reset = 1'b0; datawidth = '0; start = 1'b0; window_len = '0;
    rx_valid = 1'b0; rx_data = '0; exp_data = '0;
    s_channel_reset = 1'b0; s_datawidth = '0; s_start = 1'b0; s_window_len = '0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    // reset state
    chk("rst err_count", err_count, 0);
    chk("rst bit_count", bit_count, 0);
    chk("rst locked", locked, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst state", dbg_state, 0);
    chk("rst sat state", s_dbg_state, 0);

    // full width, window of 10, clean data
    pulse_start(3'd5, 16'd10);
    chk("t2 busy", busy, 1);
    chk("t2 state sync", dbg_state, 1);
    send_clean(4, 0);
    chk("t2 no early lock", locked, 0);
    send_clean(1, 1);
    chk("t2 locked", locked, 1);
    send_clean(9, 1);
    exp_q.push_back({32'(m_err), 32'(m_bit)});
    chk("t2 done not early", done, 0);
    @(negedge clock);
    chk("t2 done latency", done, 1);
    chk("t2 busy clear", busy, 0);
    check_result("t2", err_count, bit_count);
    chk("t2 bit_count 320", bit_count, 320);

    // 8 lanes, bit 8 must be masked
    pulse_start(3'd3, 16'd4);
    send_clean(4, 0);
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      send(r, r ^ 32'h0000_01FF, 1);
    end
    exp_q.push_back({32'(m_err), 32'(m_bit)});
    wait_done("t3 done", 8);
    check_result("t3", err_count, bit_count);
    chk("t3 err_count 32", err_count, 32);

    // errored word during SYNC restarts the lock streak
    pulse_start(3'd5, 16'd2);
    chk("t4 counts kept in sync", err_count, 32);
    send_clean(3, 0);
    r = $urandom;
    send(r, r ^ 32'h8000_0001, 0);
    send_clean(3, 0);
    @(negedge clock);
    chk("t4 no lock after 3", locked, 0);
    chk("t4 errored word not counted", err_count, 32);
    send_clean(1, 0);
    @(negedge clock);
    chk("t4 locked after 4", locked, 1);
    chk("t4 counts cleared at lock", err_count, 0);
    for (int i = 0; i < 2; i++) begin
      r = $urandom;
      send(r, r ^ (32'd1 << $urandom_range(0, 31)), 1);
    end
    exp_q.push_back({32'(m_err), 32'(m_bit)});
    wait_done("t4 done", 8);
    check_result("t4", err_count, bit_count);

    // start ignored in MEASURE, channel_reset overrides start
    pulse_start(3'd5, 16'd0);
    send_clean(4, 0);
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      send(r, ~r, 1);
    end
    @(negedge clock);
    chk("t5 err before abort", err_count, 32'(m_err));
    pulse_start(3'd2, 16'd1);
    chk("t5 start ignored", dbg_state, 2);
    channel_reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    channel_reset = 1'b0;
    start = 1'b0;
    chk("t5 state idle", dbg_state, 0);
    chk("t5 err cleared", err_count, 0);
    chk("t5 bit cleared", bit_count, 0);
    chk("t5 busy", busy, 0);
    chk("t5 locked", locked, 0);
    @(negedge clock);
    chk("t5 still idle", dbg_state, 0);

    // 8-bit counters saturate, window 0 never finishes
    s_datawidth = 3'd5;
    s_window_len = 16'd0;
    s_start = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    set_model(3'd5);
    send_clean(4, 0);
    for (int i = 0; i < 7; i++) begin
      r = $urandom;
      send(r, ~r, 1);
    end
    exp_q.push_back({32'(sat8(m_err)), 32'(sat8(m_bit))});
    @(negedge clock);
    check_result("t6 pre-sat", 32'(s_err_count), 32'(s_bit_count));
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      send(r, ~r, 1);
    end
    exp_q.push_back({32'(sat8(m_err)), 32'(sat8(m_bit))});
    @(negedge clock);
    check_result("t6 sat", 32'(s_err_count), 32'(s_bit_count));
    chk("t6 err 255", s_err_count, 255);
    chk("t6 done stays 0", s_done, 0);
    chk("t6 still measuring", s_dbg_state, 2);
    chk("t6 main untouched", dbg_state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
